// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus bit-serial shift and shift-add
// multiply, with a start/busy/done handshake and registered result and flags.
module alu_seq #(
  parameter int W     = 8,
  parameter int IMM_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_cmd,
  input  logic             direct,
  input  logic [IMM_W-1:0] immed,
  input  logic [W-1:0]     inA,
  input  logic [W-1:0]     inB,
  input  logic             sc_i,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     rslt,
  output logic             sc_o,
  output logic             pari,
  output logic             zero,
  output logic             br_logic
);

  localparam int CNT_W = $clog2(2 * W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [3:0] OP_LDR   = 4'd0;
  localparam logic [3:0] OP_STR   = 4'd1;
  localparam logic [3:0] OP_MOV   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_SHIFT = 4'd5;
  localparam logic [3:0] OP_CMP   = 4'd6;
  localparam logic [3:0] OP_ADD   = 4'd8;
  localparam logic [3:0] OP_SUB   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;

  logic [1:0]       state;
  logic             is_mul;
  logic             dir;
  logic             fill;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     opa;
  logic [2*W-1:0]   acc;

  logic             accept;
  logic             multi;
  logic [W-1:0]     one_rslt;
  logic             one_c;
  logic             one_br;
  logic [W:0]       sum;
  logic [W:0]       mul_hi;
  logic [2*W-1:0]   step_acc;
  logic             step_cy;

  // FIN is the done cycle; it accepts a new start just like IDLE.
  assign accept = start && (state != S_RUN);
  assign multi  = (alu_cmd == OP_MUL) || ((alu_cmd == OP_SHIFT) && (immed != '0));
  assign busy   = (state == S_RUN);
  assign done   = (state == S_FIN);
  assign pari   = ^rslt;
  assign zero   = ~|rslt;

  always_comb begin
    one_rslt = '0;
    one_c    = 1'b0;
    one_br   = 1'b0;
    sum      = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
    case (alu_cmd)
      OP_LDR:   one_rslt = inA;
      OP_STR:   one_rslt = inB;
      OP_MOV:   one_rslt = W'(immed);
      OP_XOR:   one_rslt = inA ^ inB;
      OP_AND:   one_rslt = inA & inB;
      OP_SHIFT: one_rslt = inA;
      OP_CMP:   one_br   = (inA == inB);
      OP_ADD: begin
        one_rslt = sum[W-1:0];
        one_c    = sum[W];
      end
      OP_SUB: begin
        one_rslt = inA - inB;
        one_c    = (inA < inB);
      end
      default: ;
    endcase
  end

  // Multiply keeps the partial product in acc[2W-1:W] and the unconsumed
  // multiplier bits in acc[W-1:0]; shifts only use acc[W-1:0].
  always_comb begin
    mul_hi   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opa} : '0);
    step_acc = acc;
    step_cy  = cy;
    if (is_mul) begin
      step_acc = {mul_hi, acc[W-1:1]};
    end else if (dir) begin
      step_acc = {acc[2*W-1:W], fill, acc[W-1:1]};
      step_cy  = acc[0];
    end else begin
      step_acc = {acc[2*W-1:W], acc[W-2:0], fill};
      step_cy  = acc[W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rslt     <= '0;
      sc_o     <= 1'b0;
      br_logic <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          if (!start) begin
            state <= S_IDLE;
          end else if (multi) begin
            state <= S_RUN;
          end else begin
            state    <= S_FIN;
            rslt     <= one_rslt;
            sc_o     <= one_c;
            br_logic <= one_br;
          end
        end
        S_RUN: begin
          if (cnt == CNT_W'(1)) begin
            state    <= S_FIN;
            rslt     <= step_acc[W-1:0];
            sc_o     <= is_mul ? (|step_acc[2*W-1:W]) : step_cy;
            br_logic <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Working registers carry no reset; they are loaded at every accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_mul <= (alu_cmd == OP_MUL);
      dir    <= direct;
      fill   <= sc_i;
      cy     <= 1'b0;
      opa    <= inA;
      acc    <= (alu_cmd == OP_MUL) ? {{W{1'b0}}, inB} : {{W{1'b0}}, inA};
      cnt    <= (alu_cmd == OP_MUL) ? CNT_W'(W) : CNT_W'(immed);
    end else if (state == S_RUN) begin
      acc <= step_acc;
      cy  <= step_cy;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes reference-model results, a
// negedge monitor pops and compares them at every done pulse.
module tb_alu_seq;

  localparam int W     = 8;
  localparam int IMM_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       alu_cmd;
  logic             direct;
  logic [IMM_W-1:0] immed;
  logic [W-1:0]     inA;
  logic [W-1:0]     inB;
  logic             sc_i;
  logic             busy;
  logic             done;
  logic [W-1:0]     rslt;
  logic             sc_o;
  logic             pari;
  logic             zero;
  logic             br_logic;

  alu_seq #(.W(W), .IMM_W(IMM_W)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_cmd(alu_cmd), .direct(direct),
    .immed(immed), .inA(inA), .inB(inB), .sc_i(sc_i), .busy(busy), .done(done),
    .rslt(rslt), .sc_o(sc_o), .pari(pari), .zero(zero), .br_logic(br_logic)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         br;
    int           done_cyc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   errors = 0;
  int   checks = 0;
  int   busy_lo = 0;
  int   busy_hi = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model; done_cyc holds the latency in cycles after accept.
  function automatic exp_t model(input logic [3:0] cmd, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [IMM_W-1:0] imm,
                                 input logic dir, input logic sci);
    exp_t e;
    logic [63:0] x;
    logic [63:0] fills;
    int n;
    e.r = '0; e.c = 1'b0; e.br = 1'b0; e.done_cyc = 0;
    n = int'(imm);
    fills = sci ? ((64'd1 << n) - 64'd1) : 64'd0;
    case (cmd)
      4'd0: e.r = a;
      4'd1: e.r = b;
      4'd2: e.r = W'(imm);
      4'd3: e.r = a ^ b;
      4'd4: e.r = a & b;
      4'd5: begin
        e.done_cyc = n;
        if (n == 0) e.r = a;
        else if (!dir) begin
          x = (64'(a) << n) | fills;
          e.r = W'(x);
          e.c = x[W];
        end else begin
          x = (fills << W) | 64'(a);
          e.r = W'(x >> n);
          e.c = x[n-1];
        end
      end
      4'd6: e.br = (a == b);
      4'd8: begin
        x = 64'(a) + 64'(b) + 64'(sci);
        e.r = W'(x);
        e.c = x[W];
      end
      4'd9: begin
        e.r = W'(64'(a) - 64'(b));
        e.c = (a < b);
      end
      4'd10: begin
        x = 64'(a) * 64'(b);
        e.r = W'(x);
        e.c = ((x >> W) != 64'd0);
        e.done_cyc = W;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [IMM_W-1:0] imm, input logic dir, input logic sci,
                       input bit expect_done = 1'b1);
    exp_t e;
    alu_cmd = cmd; inA = a; inB = b; immed = imm; direct = dir; sc_i = sci;
    start = 1'b1;
    e = model(cmd, a, b, imm, dir, sci);
    @(posedge clk);
    #1;
    start = 1'b0;
    e.done_cyc += cyc;
    busy_lo = cyc;
    busy_hi = e.done_cyc;
    if (expect_done) q.push_back(e);
    // Operand changes after accept must not matter.
    inA = W'($urandom); inB = W'($urandom); alu_cmd = 4'($urandom);
    immed = IMM_W'($urandom); direct = 1'($urandom); sc_i = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int k = 0; k < W + 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done, expected done (cycle %0d)", cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rslt"}, rslt, 0);
    chk({tag, "_sc_o"}, sc_o, 0);
    chk({tag, "_br"}, br_logic, 0);
    chk({tag, "_pari"}, pari, 0);
    chk({tag, "_zero"}, zero, 1);
  endtask

  // Monitor: busy window every cycle, scoreboard pop on every done.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, (cyc >= busy_lo && cyc < busy_hi));
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done, expected none (cycle %0d)", cyc);
        end else begin
          m = q.pop_front();
          chk("rslt", rslt, m.r);
          chk("sc_o", sc_o, m.c);
          chk("br_logic", br_logic, m.br);
          chk("pari", pari, ^m.r);
          chk("zero", zero, (m.r == '0));
          chk("done_cycle", cyc, m.done_cyc);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; alu_cmd = '0; direct = 1'b0; immed = '0;
    inA = '0; inB = '0; sc_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("reset");
    mon_en = 1'b1;

    issue(4'd8, 8'hFF, 8'h01, 0, 1'b0, 1'b0); wait_done();
    issue(4'd5, 8'hA1, 8'h00, 3, 1'b0, 1'b0); wait_done();
    issue(4'd5, 8'h81, 8'h00, 2, 1'b1, 1'b1); wait_done();
    issue(4'd10, 8'd13, 8'd11, 0, 1'b0, 1'b0); wait_done();
    issue(4'd10, 8'd20, 8'd20, 0, 1'b0, 1'b0); wait_done();
    issue(4'd6, 8'h5A, 8'h5A, 0, 1'b0, 1'b0); wait_done();
    issue(4'd3, 8'h0F, 8'hF0, 0, 1'b0, 1'b0); wait_done();
    issue(4'd9, 8'h03, 8'h05, 0, 1'b0, 1'b0); wait_done();
    issue(4'd5, 8'h3C, 8'h00, 12, 1'b0, 1'b1); wait_done();
    issue(4'd5, 8'hC3, 8'h00, 8, 1'b1, 1'b0); wait_done();
    issue(4'd5, 8'h80, 8'h00, 8, 1'b0, 1'b0); wait_done();
    issue(4'd5, 8'h5A, 8'h00, 0, 1'b1, 1'b1); wait_done();
    issue(4'd12, 8'h77, 8'h11, 0, 1'b0, 1'b1); wait_done();

    // Start during a multiply is ignored; a start in the done cycle is taken.
    issue(4'd10, 8'd7, 8'd9, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    alu_cmd = 4'd0; inA = 8'h42; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    issue(4'd2, 8'h00, 8'h00, 2, 1'b0, 1'b0); wait_done();

    // Reset in the middle of a multiply aborts it.
    issue(4'd10, 8'hFF, 8'hFF, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    busy_hi = cyc;
    check_reset_outputs("abort");
    reset = 1'b0;
    issue(4'd8, 8'h10, 8'h20, 0, 1'b0, 1'b1); wait_done();

    for (int i = 0; i < 150; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), IMM_W'($urandom),
            1'($urandom), 1'($urandom));
      wait_done();
    end

    repeat (20) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the datapath ALU. It adds a start/busy/done handshake, registered results and flags, and configurable data and immediate widths. It also adds arithmetic (add/sub with carry) and multi-cycle operations: a bit-serial shift by immediate and a shift-add multiply. It sits between the register file and the writeback/branch logic, and the controller stalls on `busy`.

## Interface
Parameters:
- `W`, 8, datapath width (≥2)
- `IMM_W`, 2, immediate / shift-count width (1..$clog2(W)+1)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; accepted only when idle (`busy`=0)
- `alu_cmd`  in  4  operation code, sampled at accept
- `direct`  in  1  shift direction: 1 = right, 0 = left
- `immed`  in  IMM_W  immediate / shift count
- `inA`, `inB`  in  W each  operands, sampled at accept
- `sc_i`  in  1  carry/shift-fill in, sampled at accept
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse when results update
- `rslt`  out  W  registered result
- `sc_o`  out  1  carry / shift-out / multiply overflow
- `pari`  out  1  XOR-reduce of `rslt`
- `zero`  out  1  1 when `rslt`==0
- `br_logic`  out  1  compare-equal flag

## Operation
- Opcodes:
  - 0 LDR: rslt=A
  - 1 STR: rslt=B
  - 2 MOV: rslt=zero-extended `immed`
  - 3 XOR: A^B
  - 4 AND: A&B
  - 5 SHIFT (multi-cycle)
  - 6 CMP: rslt=0, br_logic=(A==B)
  - 7 BR: rslt=0
  - 8 ADD: {sc_o,rslt}=A+B+sc_i
  - 9 SUB: rslt=A−B mod 2^W, sc_o=1 iff A<B (borrow)
  - 10 MUL (multi-cycle)
  - 11–15 reserved: rslt=0, sc_o=0, single-cycle
- `sc_o`=0 for every op not listed as producing it.
- `br_logic`=0 at every done except a CMP with A==B.
- SHIFT: n=`immed` steps, one bit per cycle.
  - Each step moves the bit that leaves (MSB for left, LSB for right) into the `sc_o` register.
  - The vacated bit is filled with the latched `sc_i`.
  - n=0: rslt=A, sc_o=0.
- MUL: unsigned shift-add over W iterations.
  - rslt = low W bits of A×B.
  - sc_o = 1 iff the high W bits are non-zero.
- `zero` and `pari` are derived from the registered `rslt` value presented at done. They are not stale from the prior operation.
- FSM states:
  - IDLE: `start` → latch operands, op and count → RUN (multi-cycle with n>0) or FIN.
  - RUN: one step per cycle; when the remaining count reaches 0 → FIN.
  - FIN: write rslt/flags, pulse `done` → IDLE.
- Results and flags hold their values between done pulses.

## Timing
- Reset: state IDLE; busy, done, rslt, sc_o, br_logic, pari = 0; `zero`=1 (consistent with rslt=0).
- Start accepted at edge t. Latency:
  - single-cycle ops and SHIFT n=0: done at t+1
  - SHIFT n>0: done at t+1+n
  - MUL: done at t+1+W
- `busy`=1 from the cycle after accept through the cycle before done. `busy`=0 in the done cycle, so a back-to-back `start` is accepted in the done cycle.
- `start` while busy is ignored and not queued. Operand or `alu_cmd` changes while busy have no effect.
- `done` is high for exactly one cycle per accepted start.
- `reset` mid-operation aborts: no done pulse, outputs return to reset values next edge.
- SHIFT count never exceeds 2^IMM_W−1. Counts ≥W yield all-fill bits. In that case `sc_o` is the last bit shifted out, which is the fill bit when n>W.

## Test plan
- Reset, then ADD, W=8: A=FF, B=01, sc_i=0 at t → done at t+1 with rslt=00, sc_o=1, zero=1, pari=0; busy never high.
- SHIFT left, immed=3: A=1010_0001, sc_i=0 → busy t+1..t+3, done t+4, rslt=0000_1000, sc_o=1. SHIFT right, immed=2: A=81, sc_i=1 → rslt=E0, sc_o=0, done t+3.
- MUL 13×11 → done t+9, rslt=8F, sc_o=0, pari=1. MUL 20×20 → rslt=90, sc_o=1.
- CMP A=B=5A → rslt=00, zero=1, br_logic=1. Following XOR 0F^F0 → rslt=FF, br_logic=0, pari=0.
- Handshake: pulse start at t+2 during a MUL → ignored, exactly one done. Start in the done cycle (MOV immed=2) → accepted, done next cycle, rslt=02.
- Assert reset at t+4 of a MUL → no done, all outputs at reset values next cycle; a new start then works normally.
